// File: rtl/wired_tl_pkg.sv
// Shared TileLink types and helpers for the wired TL memory device.
package wired_tl_pkg;

    localparam int unsigned TL_MAX_SIZE  = 6;
    localparam int unsigned TL_DATA_W    = 128;
    localparam int unsigned TL_MASK_W    = 16;
    localparam int unsigned TL_CNT_W     = 12;

    typedef enum logic [2:0] {
        TL_A_PUT_FULL    = 3'd0,
        TL_A_PUT_PARTIAL = 3'd1,
        TL_A_ARITH       = 3'd2,
        TL_A_LOGIC       = 3'd3,
        TL_A_GET         = 3'd4,
        TL_A_INTENT      = 3'd5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        TL_D_ACCESS_ACK      = 3'd0,
        TL_D_ACCESS_ACK_DATA = 3'd1,
        TL_D_HINT_ACK        = 3'd2
    } tl_d_op_e;

    typedef struct packed {
        tl_a_op_e    op;
        logic [3:0]  size;
        logic        denied;
    } tl_hdr_t;

    typedef struct packed {
        tl_d_op_e               op;
        logic                   denied;
        logic                   corrupt;
        logic [TL_DATA_W-1:0]   data;
    } tl_d_beat_t;

    // Number of 16-byte beats carried by a message of 2**size bytes.
    function automatic logic [TL_CNT_W-1:0] tl_beats(input logic [3:0] size);
        if (size <= 4'd4) begin
            return TL_CNT_W'(1);
        end
        return TL_CNT_W'(1) << (size - 4'd4);
    endfunction

endpackage

// File: rtl/wired_tl_mem_sram.sv
// Single-port 128-bit SRAM with byte enables and a registered read port.
module wired_tl_mem_sram
    import wired_tl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [TL_MASK_W-1:0]  be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [TL_DATA_W-1:0]  wdata,
    output logic [TL_DATA_W-1:0]  rdata
);

    logic [TL_DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < int'(TL_MASK_W); b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wired_tl_mem_device.sv
// TileLink UH responder serving A-channel requests from an internal SRAM.
module wired_tl_mem_device
    import wired_tl_pkg::*;
#(
    parameter int unsigned SOURCE_WIDTH = 2,
    parameter int unsigned SINK_WIDTH   = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned MAX_SIZE     = TL_MAX_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tl_a_valid,
    output logic                     tl_a_ready,
    input  logic [2:0]               tl_a_opcode,
    input  logic [2:0]               tl_a_param,
    input  logic [3:0]               tl_a_size,
    input  logic [SOURCE_WIDTH-1:0]  tl_a_source,
    input  logic [31:0]              tl_a_address,
    input  logic [TL_MASK_W-1:0]     tl_a_mask,
    input  logic                     tl_a_corrupt,
    input  logic [TL_DATA_W-1:0]     tl_a_data,
    output logic                     tl_d_valid,
    input  logic                     tl_d_ready,
    output logic [2:0]               tl_d_opcode,
    output logic [1:0]               tl_d_param,
    output logic [3:0]               tl_d_size,
    output logic [SOURCE_WIDTH-1:0]  tl_d_source,
    output logic [SINK_WIDTH-1:0]    tl_d_sink,
    output logic                     tl_d_denied,
    output logic                     tl_d_corrupt,
    output logic [TL_DATA_W-1:0]     tl_d_data
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned MEM_BYTES = DEPTH_WORDS * 16;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;

    state_e                   state_q, state_d;
    tl_hdr_t                  hdr_q;
    logic [SOURCE_WIDTH-1:0]  src_q;
    logic [ADDR_W-1:0]        word_q;
    logic [TL_CNT_W-1:0]      beats_q, a_cnt_q, d_cnt_q;
    logic                     rd_pend_q, a_ready_q;
    tl_d_beat_t               out_q, skid_q;
    logic                     out_valid_q, skid_valid_q;

    // Request decode on the first A beat
    tl_a_op_e             a_op;
    logic                 a_op_known, a_denied;
    logic [31:0]          a_offset;
    logic [ADDR_W-1:0]    a_word;
    logic [TL_CNT_W-1:0]  a_beats;

    assign a_op       = tl_a_op_e'(tl_a_opcode);
    assign a_op_known = tl_a_opcode <= 3'd5;
    assign a_offset   = tl_a_address - BASE_ADDR;
    assign a_word     = a_offset[ADDR_W+3:4];
    assign a_beats    = tl_beats(tl_a_size);
    assign a_denied   = (tl_a_size > 4'(MAX_SIZE))
                     || ((tl_a_address & ((32'd1 << tl_a_size) - 32'd1)) != 32'd0)
                     || (tl_a_address < BASE_ADDR)
                     || (a_offset >= 32'(MEM_BYTES));

    logic                  sram_en, sram_we;
    logic [TL_MASK_W-1:0]  sram_be;
    logic [ADDR_W-1:0]     sram_addr;
    logic [TL_DATA_W-1:0]  sram_rdata;

    logic first_hs, beat_hs, issue, load_resp, last_pop, pop, out_free, room;
    logic [1:0] occ;
    logic [TL_CNT_W-1:0] resp_last;
    tl_d_beat_t resp_beat, rd_beat;

    assign pop      = out_valid_q && tl_d_ready;
    assign out_free = !out_valid_q || pop;
    // Words already buffered or in flight must leave space for the one issued now
    assign occ      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
    assign room     = (occ - 2'(pop)) <= 2'd1;
    assign resp_last = (hdr_q.op == TL_A_ARITH || hdr_q.op == TL_A_LOGIC)
                     ? beats_q - TL_CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle SRAM / buffer control
    always_comb begin
        state_d   = state_q;
        first_hs  = 1'b0;
        beat_hs   = 1'b0;
        issue     = 1'b0;
        load_resp = 1'b0;
        last_pop  = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_be   = '0;
        sram_addr = word_q + ADDR_W'(a_cnt_q);
        unique case (state_q)
            ST_IDLE: begin
                if (tl_a_valid && a_op_known) begin
                    first_hs  = 1'b1;
                    sram_addr = a_word;
                    case (a_op)
                        TL_A_GET: begin
                            state_d = ST_READ;
                            issue   = 1'b1;
                            sram_en = !a_denied;
                        end
                        TL_A_INTENT: begin
                            state_d   = ST_RESP;
                            load_resp = 1'b1;
                        end
                        default: begin
                            sram_en = (a_op <= TL_A_PUT_PARTIAL) && !a_denied && !tl_a_corrupt;
                            sram_we = 1'b1;
                            sram_be = (a_op == TL_A_PUT_FULL) ? '1 : tl_a_mask;
                            if (a_beats == TL_CNT_W'(1)) begin
                                state_d   = ST_RESP;
                                load_resp = 1'b1;
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                if (tl_a_valid) begin
                    beat_hs = 1'b1;
                    sram_en = (hdr_q.op <= TL_A_PUT_PARTIAL) && !hdr_q.denied && !tl_a_corrupt;
                    sram_we = 1'b1;
                    sram_be = (hdr_q.op == TL_A_PUT_FULL) ? '1 : tl_a_mask;
                    if (a_cnt_q == beats_q - TL_CNT_W'(1)) begin
                        state_d   = ST_RESP;
                        load_resp = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (a_cnt_q < beats_q && room) begin
                    issue   = 1'b1;
                    sram_en = !hdr_q.denied;
                end
                if (pop && d_cnt_q == beats_q - TL_CNT_W'(1)) begin
                    state_d  = ST_IDLE;
                    last_pop = 1'b1;
                end
            end
            ST_RESP: begin
                if (pop && d_cnt_q == resp_last) begin
                    state_d  = ST_IDLE;
                    last_pop = 1'b1;
                end
            end
        endcase
        // A burst cut by reset leaves the current beat unwritten
        if (rst) begin
            sram_en = 1'b0;
            sram_we = 1'b0;
        end
    end

    // Response payloads for non-read messages and for returning read words
    always_comb begin
        tl_a_op_e r_op;
        logic     r_den;
        r_op  = (state_q == ST_IDLE) ? a_op : hdr_q.op;
        r_den = (state_q == ST_IDLE) ? a_denied : hdr_q.denied;
        resp_beat        = '0;
        resp_beat.op     = TL_D_ACCESS_ACK;
        resp_beat.denied = r_den;
        case (r_op)
            TL_A_INTENT: resp_beat.op = TL_D_HINT_ACK;
            TL_A_ARITH, TL_A_LOGIC: begin
                resp_beat.op      = TL_D_ACCESS_ACK_DATA;
                resp_beat.denied  = 1'b1;
                resp_beat.corrupt = 1'b1;
            end
            default: resp_beat.op = TL_D_ACCESS_ACK;
        endcase
        rd_beat         = '0;
        rd_beat.op      = TL_D_ACCESS_ACK_DATA;
        rd_beat.denied  = hdr_q.denied;
        rd_beat.corrupt = hdr_q.denied;
        rd_beat.data    = hdr_q.denied ? '0 : sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q        <= '0;
            src_q        <= '0;
            word_q       <= '0;
            beats_q      <= '0;
            a_cnt_q      <= '0;
            d_cnt_q      <= '0;
            rd_pend_q    <= 1'b0;
            a_ready_q    <= 1'b1;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            a_ready_q <= (state_d == ST_IDLE) || (state_d == ST_WRITE);
            rd_pend_q <= issue;
            if (first_hs) begin
                hdr_q.op     <= a_op;
                hdr_q.size   <= tl_a_size;
                hdr_q.denied <= a_denied;
                src_q        <= tl_a_source;
                word_q       <= a_word;
                beats_q      <= a_beats;
                a_cnt_q      <= TL_CNT_W'(1);
                d_cnt_q      <= '0;
            end else begin
                if (beat_hs || issue) a_cnt_q <= a_cnt_q + TL_CNT_W'(1);
                if (pop)              d_cnt_q <= d_cnt_q + TL_CNT_W'(1);
            end
            // Output register backed by a one-entry skid for read data
            if (load_resp) begin
                out_q       <= resp_beat;
                out_valid_q <= 1'b1;
            end else if (state_q == ST_RESP) begin
                if (last_pop) out_valid_q <= 1'b0;
            end else if (out_free) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= rd_pend_q;
                    skid_q       <= rd_beat;
                end else begin
                    out_valid_q <= rd_pend_q;
                    if (rd_pend_q) out_q <= rd_beat;
                end
            end else if (rd_pend_q) begin
                skid_q       <= rd_beat;
                skid_valid_q <= 1'b1;
            end
        end
    end

    wired_tl_mem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .be    (sram_be),
        .addr  (sram_addr),
        .wdata (tl_a_data),
        .rdata (sram_rdata)
    );

    assign tl_a_ready   = a_ready_q;
    assign tl_d_valid   = out_valid_q;
    assign tl_d_opcode  = out_q.op;
    assign tl_d_param   = '0;
    assign tl_d_size    = hdr_q.size;
    assign tl_d_source  = src_q;
    assign tl_d_sink    = '0;
    assign tl_d_denied  = out_q.denied;
    assign tl_d_corrupt = out_q.corrupt;
    assign tl_d_data    = out_q.data;

    logic unused_a;
    assign unused_a = ^tl_a_param;

    // Reserved opcodes are swallowed with a_ready high
    assert property (@(posedge clk) disable iff (rst)
        !(state_q == ST_IDLE && tl_a_valid && !a_op_known))
        else $error("wired_tl_mem_device: reserved A opcode %0d dropped", tl_a_opcode);

endmodule

// File: tb/tb_wired_tl_mem_device.sv
// Directed bench for wired_tl_mem_device with hand-computed expectations.
module tb_wired_tl_mem_device;

    localparam logic [2:0] OP_PUT_FULL = 3'd0, OP_PUT_PART = 3'd1, OP_ARITH = 3'd2,
                           OP_GET = 3'd4, OP_INTENT = 3'd5;
    localparam logic [2:0] D_ACK = 3'd0, D_ACK_DATA = 3'd1, D_HINT = 3'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic         tl_a_valid, tl_a_ready;
    logic [2:0]   tl_a_opcode, tl_a_param;
    logic [3:0]   tl_a_size;
    logic [1:0]   tl_a_source;
    logic [31:0]  tl_a_address;
    logic [15:0]  tl_a_mask;
    logic         tl_a_corrupt;
    logic [127:0] tl_a_data;
    logic         tl_d_valid, tl_d_ready;
    logic [2:0]   tl_d_opcode;
    logic [1:0]   tl_d_param;
    logic [3:0]   tl_d_size;
    logic [1:0]   tl_d_source;
    logic [0:0]   tl_d_sink;
    logic         tl_d_denied, tl_d_corrupt;
    logic [127:0] tl_d_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] wdata    [4];
    logic [127:0] exp_data [8];

    always #5 clk = ~clk;

    wired_tl_mem_device dut (
        .clk(clk), .rst(rst),
        .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
        .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
        .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_corrupt(tl_a_corrupt),
        .tl_a_data(tl_a_data),
        .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
        .tl_d_param(tl_d_param), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
        .tl_d_sink(tl_d_sink), .tl_d_denied(tl_d_denied), .tl_d_corrupt(tl_d_corrupt),
        .tl_d_data(tl_d_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a posedge; returns just after the handshake edge.
    task automatic send_beat(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                             input logic [31:0] addr, input logic [15:0] mask,
                             input logic [127:0] data, input logic corrupt);
        int n = 0;
        tl_a_valid = 1'b1; tl_a_opcode = op; tl_a_size = size; tl_a_source = src;
        tl_a_address = addr; tl_a_mask = mask; tl_a_data = data; tl_a_corrupt = corrupt;
        @(negedge clk);
        while (!tl_a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tl_a_ready) check("a_ready_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        tl_a_valid = 1'b0;
    endtask

    task automatic put_msg(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                           input logic [31:0] addr, input logic [15:0] mask);
        int beats = (size <= 4) ? 1 : (1 << (size - 4));
        for (int b = 0; b < beats; b++) send_beat(op, size, src, addr, mask, wdata[b], 1'b0);
    endtask

    // Expects a single-beat response one cycle after the last A beat.
    task automatic expect_ack(input string tag, input logic [2:0] op, input logic den,
                              input logic cor, input logic [1:0] src, input logic [3:0] size);
        @(negedge clk);
        check({tag, "_valid"},   tl_d_valid, 1'b1);
        check({tag, "_opcode"},  tl_d_opcode, op);
        check({tag, "_denied"},  tl_d_denied, den);
        check({tag, "_corrupt"}, tl_d_corrupt, cor);
        check({tag, "_source"},  tl_d_source, src);
        check({tag, "_size"},    tl_d_size, size);
        @(negedge clk);
        check({tag, "_single"},  tl_d_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    // Get with a repeating d_ready pattern (bit k of rpat used on stall-cycle k).
    task automatic do_get(input string tag, input logic [3:0] size, input logic [31:0] addr,
                          input logic [1:0] src, input logic den, input logic [3:0] rpat,
                          input int rlen);
        int beats = (size <= 4) ? 1 : (1 << (size - 4));
        int got = 0;
        int k = 0;
        int n = 0;
        logic stalled = 1'b0;
        logic [127:0] held = '0;
        send_beat(OP_GET, size, src, addr, 16'hFFFF, '0, 1'b0);
        @(negedge clk);
        check({tag, "_lat1"}, tl_d_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat2"}, tl_d_valid, 1'b1);
        check({tag, "_source"}, tl_d_source, src);
        check({tag, "_size"}, tl_d_size, size);
        while (got < beats && n < 200) begin
            if (tl_d_valid) begin
                if (stalled) check({tag, "_hold"}, tl_d_data, held);
                tl_d_ready = rpat[k % rlen];
                k++;
                if (tl_d_ready) begin
                    check($sformatf("%s_data%0d", tag, got), tl_d_data, exp_data[got]);
                    check($sformatf("%s_op%0d", tag, got), tl_d_opcode, D_ACK_DATA);
                    check($sformatf("%s_den%0d", tag, got), tl_d_denied, den);
                    check($sformatf("%s_cor%0d", tag, got), tl_d_corrupt, den);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = tl_d_data;
                end
            end
            @(negedge clk);
            n++;
        end
        if (got < beats) check({tag, "_beat_timeout"}, 128'(got), 128'(beats));
        tl_d_ready = 1'b1;
        check({tag, "_end"}, tl_d_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tl_a_valid = 1'b0; tl_a_opcode = '0; tl_a_param = '0; tl_a_size = '0;
        tl_a_source = '0; tl_a_address = '0; tl_a_mask = '0; tl_a_corrupt = 1'b0;
        tl_a_data = '0; tl_d_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", tl_a_ready, 1'b1);
        check("rst_d_valid", tl_d_valid, 1'b0);
        check("rst_d_data",  tl_d_data, '0);
        check("rst_d_denied", tl_d_denied, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-beat PutFull then readback
        wdata[0] = {16{8'hA5}};
        put_msg(OP_PUT_FULL, 4'd4, 2'd1, 32'h10, 16'hFFFF);
        expect_ack("put_a5", D_ACK, 1'b0, 1'b0, 2'd1, 4'd4);
        exp_data[0] = {16{8'hA5}};
        do_get("get_a5", 4'd4, 32'h10, 2'd1, 1'b0, 4'b1111, 1);

        // PutPartial merges low 4 bytes into an all-FF word
        wdata[0] = {16{8'hFF}};
        put_msg(OP_PUT_FULL, 4'd4, 2'd0, 32'h20, 16'hFFFF);
        expect_ack("put_ff", D_ACK, 1'b0, 1'b0, 2'd0, 4'd4);
        wdata[0] = 128'h11223344;
        put_msg(OP_PUT_PART, 4'd4, 2'd0, 32'h20, 16'h000F);
        expect_ack("put_part", D_ACK, 1'b0, 1'b0, 2'd0, 4'd4);
        exp_data[0] = {{96{1'b1}}, 32'h11223344};
        do_get("get_part", 4'd4, 32'h20, 2'd0, 1'b0, 4'b1111, 1);

        // 4-beat burst write and stalled readback
        wdata[0] = {4{32'hD0D0_0000}}; wdata[1] = {4{32'hD1D1_1111}};
        wdata[2] = {4{32'hD2D2_2222}}; wdata[3] = {4{32'hD3D3_3333}};
        put_msg(OP_PUT_FULL, 4'd6, 2'd2, 32'h40, 16'hFFFF);
        expect_ack("put_burst", D_ACK, 1'b0, 1'b0, 2'd2, 4'd6);
        for (int i = 0; i < 4; i++) exp_data[i] = wdata[i];
        do_get("get_burst", 4'd6, 32'h40, 2'd3, 1'b0, 4'b1001, 4);

        // Denied requests
        for (int i = 0; i < 8; i++) exp_data[i] = '0;
        do_get("get_size7", 4'd7, 32'h0, 2'd0, 1'b1, 4'b1111, 1);
        do_get("get_misalign", 4'd4, 32'h8, 2'd1, 1'b1, 4'b1111, 1);
        do_get("get_oob", 4'd4, 32'h0001_0000, 2'd2, 1'b1, 4'b1111, 1);
        wdata[0] = 128'h0BAD;
        put_msg(OP_PUT_FULL, 4'd4, 2'd1, 32'h18, 16'hFFFF);
        expect_ack("put_misalign", D_ACK, 1'b1, 1'b0, 2'd1, 4'd4);

        // Intent and atomic responses
        put_msg(OP_INTENT, 4'd4, 2'd3, 32'h10, 16'hFFFF);
        expect_ack("intent", D_HINT, 1'b0, 1'b0, 2'd3, 4'd4);
        put_msg(OP_ARITH, 4'd4, 2'd2, 32'h10, 16'hFFFF);
        expect_ack("arith", D_ACK_DATA, 1'b1, 1'b1, 2'd2, 4'd4);
        exp_data[0] = {16{8'hA5}};
        do_get("get_unchanged", 4'd4, 32'h10, 2'd0, 1'b0, 4'b1111, 1);

        // Reset during beat 2 of a 4-beat PutFull
        wdata[0] = {16{8'hC0}}; wdata[1] = {16{8'hC1}}; wdata[2] = {16{8'hC2}}; wdata[3] = {16{8'hC3}};
        put_msg(OP_PUT_FULL, 4'd6, 2'd0, 32'h80, 16'hFFFF);
        expect_ack("put_fill", D_ACK, 1'b0, 1'b0, 2'd0, 4'd6);
        send_beat(OP_PUT_FULL, 4'd6, 2'd0, 32'h80, 16'hFFFF, {16{8'hE0}}, 1'b0);
        send_beat(OP_PUT_FULL, 4'd6, 2'd0, 32'h80, 16'hFFFF, {16{8'hE1}}, 1'b0);
        tl_a_valid = 1'b1; tl_a_data = {16{8'hE2}}; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tl_a_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_a_ready", tl_a_ready, 1'b1);
        check("rst_mid_d_valid", tl_d_valid, 1'b0);
        @(negedge clk);
        check("rst_mid_no_d", tl_d_valid, 1'b0);
        @(posedge clk); #1;
        exp_data[0] = {16{8'hE0}}; exp_data[1] = {16{8'hE1}};
        exp_data[2] = {16{8'hC2}}; exp_data[3] = {16{8'hC3}};
        do_get("get_after_rst", 4'd6, 32'h80, 2'd1, 1'b0, 4'b1111, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
